cart_round_ctrl: RTL and testbench
==================================

# cart_round_ctrl

Round sequencer for the two-player cart game. It owns the game state machine (idle, countdown, run, over), generates the barrier scroll tick whose period depends on the selected level, and arbitrates bomb (barrier-wipe) requests. It also latches the round winner from the two crash flags. It sits between the player/level inputs and the barrier generator/shifter chain, gating every scroll and clear that chain sees.

## Interface
- `BASE_PERIOD`, default 16: scroll period in clk cycles at level 0.
- `STEP`, default 2: cycles removed per level; `BASE_PERIOD > 7*STEP` is required.
- `COUNT_TICKS`, default 3: countdown length in scroll periods, range 1..3.
- `BOMBS`, default 2: bombs per round, range 0..3.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `start`  in  1  start/restart button, already synchronized and debounced.
- `levelS`  in  3  level select.
- `die1`, `die2`  in  1 each  crash flags from the per-player game logic.
- `bom`  in  1  bomb request button, synchronized.
- `scroll`  out  1  one-cycle pulse; advances the barrier generator and shifters.
- `clear`  out  1  one-cycle pulse; wipes all barrier rows.
- `state`  out  2  current state, `cart_pkg::round_t`.
- `count_val`  out  2  countdown digit for HEX display.
- `winner`  out  2  `00` none, `01` P1, `10` P2, `11` draw.
- `bombs_left`  out  2  remaining bombs.

## Operation
- States: IDLE, COUNT, RUN, OVER.
- `start` and `bom` are edge-detected internally. Only rising edges act.
- **IDLE:**
  - On a start edge, latch `levelS` into `lvl`, load `bombs_left=BOMBS` and `count_val=COUNT_TICKS`, pulse `clear`, go to COUNT.
- **COUNT:**
  - Timer runs with period `P = BASE_PERIOD - lvl*STEP`.
  - At each period end, `count_val` decrements.
  - At the end of the period in which `count_val==1`, `count_val` becomes 0 and the FSM goes to RUN. The timer restarts.
  - No `scroll` pulses in COUNT.
- **RUN:**
  - `scroll` pulses at each period end.
  - On a bom edge with `bombs_left>0`: pulse `clear`, decrement `bombs_left`, restart the timer. No scroll fires that cycle.
  - A bom edge with `bombs_left==0` is ignored.
- **RUN, crash exit:**
  - If `die1|die2` is sampled high, go to OVER.
  - `winner` = {die1, die2} mapped as: die2 only → `01`; die1 only → `10`; both → `11`.
- **OVER:**
  - All pulses are suppressed and `winner` holds.
  - A start edge behaves exactly like the start edge in IDLE. `winner` resets to `00`.
- **Ignored inputs:**
  - `levelS` changes after latching are ignored until the next start.
  - Start edges in COUNT and RUN are ignored.
  - `die*` outside RUN is ignored.
- **Simultaneous events in RUN:**
  - die beats bomb: go to OVER, no `clear`, bombs are not consumed.
  - die beats the scroll period end: no `scroll`.
  - A bom edge on a period-end cycle: `clear` wins, no `scroll`, and the timer restarts.

## Timing
- **Reset** (async, while `reset`=0):
  - state IDLE; `scroll`, `clear` = 0.
  - `count_val` = 0, `winner` = `00`, `bombs_left` = BOMBS.
  - Timer and edge-detect registers cleared.
- All outputs are registered.
- **Start edge at cycle N** (start=1 at N, 0 at N-1):
  - `clear`=1 and state=COUNT at N+1.
  - The timer counts from N+1.
- **Period end:** occurs P cycles after a timer (re)start. The pulse is visible at that cycle +1.
- **RUN entry:** COUNT lasts `COUNT_TICKS*P` cycles. The first `scroll` comes P cycles after RUN entry, then one every P cycles.
- **Crash:** die sampled at cycle M gives state=OVER and a valid `winner` at M+1.
- **Bomb:** bom edge at cycle M gives `clear` at M+1 and the decremented `bombs_left` at M+1.
- **Reset mid-round:** everything returns to its reset values immediately. No pulse is generated on reset release.

## Structure
- `cart_pkg`:
  - `round_t` enum (IDLE=0, COUNT=1, RUN=2, OVER=3).
  - Winner constants `WIN_NONE`, `WIN_P1`, `WIN_P2`, `WIN_DRAW`.
- Sub-module `tick_timer`:
  - Programmable period down-counter, width `$clog2(BASE_PERIOD+1)`.
  - Inputs: `period`, `restart`, `en`. Output: `done` pulse.
- The FSM, edge detects, bomb counter and winner latch live in `cart_round_ctrl`.

## Test plan
All scenarios use BASE_PERIOD=16, STEP=2, COUNT_TICKS=3, BOMBS=2.
- **Level 0 round:** levelS=0, start edge at cycle 10 → `clear` at 11; `count_val` steps 3,2,1 and reaches 0 with state=RUN at 59; `scroll` pulses at 75, 91, 107, …
- **Level 7 round:** levelS=7 gives P=2 → `scroll` every 2 cycles. Changing levelS to 0 mid-RUN leaves the period at 2.
- **Bomb handling:** three bom edges in RUN → two `clear` pulses, `bombs_left` 2→1→0, third ignored. A bom edge coinciding with a period end gives no scroll, and the next scroll comes P cycles later.
- **Crash outcomes:**
  - die2 alone → OVER, `winner=01`.
  - die1 and die2 in the same cycle → `11`.
  - die1 and a bom edge in the same cycle → no `clear`, `bombs_left` unchanged.
- **Restart from OVER:** start edge in OVER → `clear` pulse, state=COUNT, `winner=00`, `bombs_left=2`.
- **Reset mid-RUN:** reset low mid-RUN → outputs at reset values asynchronously. After release, no `scroll` or `clear` until a new start edge.

Source files
------------

// File: rtl/cart_round_ctrl_pkg.sv
// Shared types for the cart round sequencer: round states and winner codes.
package cart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    RUN   = 2'd2,
    OVER  = 2'd3
  } round_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/cart_round_ctrl_if.sv
// Player/level inputs and barrier-chain controls of the round sequencer.
interface cart_round_ctrl_if;
  import cart_pkg::*;

  logic       start;
  logic [2:0] levelS;
  logic       die1;
  logic       die2;
  logic       bom;

  logic       scroll;
  logic       clear;
  round_t     state;
  logic [1:0] count_val;
  logic [1:0] winner;
  logic [1:0] bombs_left;

  modport master (
    output start, levelS, die1, die2, bom,
    input  scroll, clear, state, count_val, winner, bombs_left
  );

  modport slave (
    input  start, levelS, die1, die2, bom,
    output scroll, clear, state, count_val, winner, bombs_left
  );
endinterface

// File: rtl/cart_round_ctrl_tick_timer.sv
// Programmable-period down-counter; done is high for one cycle every
// `period` cycles while enabled, counting from the most recent restart.
module tick_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] period,
  input  logic         restart,
  input  logic         en,
  output logic         done
);
  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] cnt;

  // A restart cycle never reports done; the new period begins on the next cycle.
  assign done = en && !restart && (cnt == '0);

  // Reload on restart or wrap, otherwise count down while enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= period - ONE;
    end else if (en) begin
      cnt <= (cnt == '0) ? period - ONE : cnt - ONE;
    end
  end
endmodule

// File: rtl/cart_round_ctrl.sv
// Round sequencer: game FSM, level-dependent scroll tick, bomb arbitration
// and winner latch. Every scroll/clear seen by the barrier chain comes from here.
module cart_round_ctrl
  import cart_pkg::*;
#(
  parameter int BASE_PERIOD = 16,
  parameter int STEP        = 2,
  parameter int COUNT_TICKS = 3,
  parameter int BOMBS       = 2
) (
  input  logic              clk,
  input  logic              reset,
  cart_round_ctrl_if.slave  bus
);
  localparam int W = $clog2(BASE_PERIOD + 1);

  logic         start_q, bom_q;
  logic         start_ev, bom_ev, crash;
  logic         begin_round, bomb_ok, done, tmr_en;
  logic [2:0]   lvl, sel_lvl;
  logic [W-1:0] period;

  round_t       state;
  logic         scroll_r, clear_r;
  logic [1:0]   count_r, winner_r, bombs_r;

  assign start_ev    = bus.start & ~start_q;
  assign bom_ev      = bus.bom & ~bom_q;
  assign crash       = bus.die1 | bus.die2;
  assign begin_round = start_ev && (state == IDLE || state == OVER);
  // A crash in the same cycle takes precedence: the bomb is neither fired nor consumed.
  assign bomb_ok     = (state == RUN) && !crash && bom_ev && (bombs_r != 2'd0);
  assign tmr_en      = (state == COUNT) || (state == RUN);

  // The level is latched on the start edge itself, so that cycle's reload
  // must already use the live selector.
  assign sel_lvl = begin_round ? bus.levelS : lvl;
  assign period  = W'(BASE_PERIOD) - W'(sel_lvl) * W'(STEP);

  tick_timer #(.W(W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .period  (period),
    .restart (begin_round || bomb_ok),
    .en      (tmr_en),
    .done    (done)
  );

  // Round FSM with registered pulses, countdown, bomb counter and winner latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      bom_q    <= 1'b0;
      lvl      <= 3'd0;
      scroll_r <= 1'b0;
      clear_r  <= 1'b0;
      count_r  <= 2'd0;
      winner_r <= WIN_NONE;
      bombs_r  <= 2'(BOMBS);
    end else begin
      start_q  <= bus.start;
      bom_q    <= bus.bom;
      scroll_r <= 1'b0;
      clear_r  <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start_ev) begin
            lvl      <= bus.levelS;
            bombs_r  <= 2'(BOMBS);
            count_r  <= 2'(COUNT_TICKS);
            winner_r <= WIN_NONE;
            clear_r  <= 1'b1;
            state    <= COUNT;
          end
        end
        COUNT: begin
          if (done) begin
            count_r <= count_r - 2'd1;
            if (count_r == 2'd1) state <= RUN;
          end
        end
        RUN: begin
          if (crash) begin
            // {die1,die2} already matches the winner encoding: 01 P1, 10 P2, 11 draw.
            winner_r <= {bus.die1, bus.die2};
            state    <= OVER;
          end else if (bomb_ok) begin
            clear_r <= 1'b1;
            bombs_r <= bombs_r - 2'd1;
          end else if (done) begin
            scroll_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.scroll     = scroll_r;
  assign bus.clear      = clear_r;
  assign bus.state      = state;
  assign bus.count_val  = count_r;
  assign bus.winner     = winner_r;
  assign bus.bombs_left = bombs_r;
endmodule

// File: tb/tb_cart_round_ctrl.sv
// Self-checking bench for cart_round_ctrl: directed scenarios plus random
// traffic, all compared against an event-time reference model.
module tb_cart_round_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;

  cart_round_ctrl_if bus();

  cart_round_ctrl #(
    .BASE_PERIOD(16), .STEP(2), .COUNT_TICKS(3), .BOMBS(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam int S_IDLE = 0, S_COUNT = 1, S_RUN = 2, S_OVER = 3;
  localparam logic [9:0] RESET_VEC = 10'b0_0_00_00_00_10;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: expected outputs after the next edge, and the absolute
  // cycle at which the next period end becomes visible.
  int m_state, m_count, m_winner, m_bombs, m_lvl, m_due;
  bit m_scroll, m_clear, p_start, p_bom;

  function automatic int period_of(int l);
    return 16 - 2 * l;
  endfunction

  function automatic logic [9:0] dut_vec();
    return {bus.scroll, bus.clear, 2'(bus.state), bus.count_val, bus.winner, bus.bombs_left};
  endfunction

  function automatic logic [9:0] model_vec();
    return {m_scroll, m_clear, 2'(m_state), 2'(m_count), 2'(m_winner), 2'(m_bombs)};
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_count = 0; m_winner = 0; m_bombs = 2; m_lvl = 0; m_due = 0;
    m_scroll = 0; m_clear = 0; p_start = 0; p_bom = 0;
  endtask

  task automatic model_step();
    int  v;
    bit  sev, bev, d1, d2;
    v   = cyc + 1;
    sev = bus.start && !p_start;
    bev = bus.bom && !p_bom;
    d1  = bus.die1;
    d2  = bus.die2;
    p_start = bus.start;
    p_bom   = bus.bom;
    m_scroll = 0;
    m_clear  = 0;
    case (m_state)
      S_IDLE, S_OVER: if (sev) begin
        m_lvl = int'(bus.levelS);
        m_due = v + period_of(m_lvl);
        m_count = 3; m_bombs = 2; m_winner = 0; m_clear = 1; m_state = S_COUNT;
      end
      S_COUNT: if (v == m_due) begin
        m_due += period_of(m_lvl);
        m_count--;
        if (m_count == 0) m_state = S_RUN;
      end
      default: begin
        if (d1 || d2) begin
          m_state  = S_OVER;
          m_winner = (d2 && !d1) ? 1 : (d1 && !d2) ? 2 : 3;
        end else if (bev && m_bombs > 0) begin
          m_clear = 1;
          m_bombs--;
          m_due = v + period_of(m_lvl);
        end else if (v == m_due) begin
          m_scroll = 1;
          m_due += period_of(m_lvl);
        end
      end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (dut_vec() !== RESET_VEC) begin
      fails++; $display("FAIL reset_vals got=%b exp=%b", dut_vec(), RESET_VEC);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    tick();
    cyc = 0;
  endtask

  task automatic test_level0();
    int s, run_at, sc1, nsc;
    bus.levelS = 3'd0;
    while (cyc < 10) begin
      tick();
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL l0_idle cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec());
      end
    end
    s = cyc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests++;
    if (bus.clear !== 1'b1 || bus.state !== S_COUNT || bus.count_val !== 2'd3) begin
      fails++; $display("FAIL l0_start got=%b exp clear=1 state=1 count=3", dut_vec());
    end
    run_at = -1; sc1 = -1; nsc = 0;
    for (int i = 0; i < 119; i++) begin
      bus.levelS = 3'($urandom_range(0, 7));
      tick();
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL l0_round cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec());
      end
      if (run_at < 0 && bus.state === S_RUN) run_at = cyc;
      if (bus.scroll === 1'b1) begin
        nsc++;
        if (sc1 < 0) sc1 = cyc;
      end
    end
    tests++;
    if (run_at - s !== 49 || sc1 - s !== 65 || nsc !== 4) begin
      fails++; $display("FAIL l0_timing run=%0d scroll1=%0d n=%0d exp 49 65 4", run_at - s, sc1 - s, nsc);
    end
  endtask

  task automatic test_crash_p1();
    bus.die2 = 1'b1;
    tick();
    bus.die2 = 1'b0;
    tests++;
    if (bus.state !== S_OVER || bus.winner !== 2'b01 || bus.scroll !== 1'b0) begin
      fails++; $display("FAIL crash_p1 got=%b exp state=3 winner=01", dut_vec());
    end
    // die and bomb inputs are ignored while OVER.
    for (int i = 0; i < 12; i++) begin
      bus.die1 = 1'($urandom_range(0, 1));
      bus.bom  = 1'($urandom_range(0, 1));
      tick();
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL over_hold cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec());
      end
    end
    bus.die1 = 1'b0; bus.bom = 1'b0;
    tick();
  endtask

  task automatic test_restart_level7();
    int prev, nsc, gap_bad;
    bus.levelS = 3'd7;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    tests++;
    if (bus.clear !== 1'b1 || bus.state !== S_COUNT || bus.winner !== 2'b00 || bus.bombs_left !== 2'd2) begin
      fails++; $display("FAIL restart got=%b exp clear=1 state=1 winner=00 bombs=2", dut_vec());
    end
    prev = -1; nsc = 0; gap_bad = 0;
    for (int i = 0; i < 46; i++) begin
      if (i == 12) bus.levelS = 3'd0;
      tick();
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL l7_round cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec());
      end
      if (bus.scroll === 1'b1) begin
        if (prev >= 0 && cyc - prev != 2) gap_bad++;
        prev = cyc;
        nsc++;
      end
    end
    tests++;
    if (gap_bad != 0 || nsc != 20) begin
      fails++; $display("FAIL l7_period bad_gaps=%0d scrolls=%0d exp 0 20", gap_bad, nsc);
    end
    bus.die1 = 1'b1; bus.die2 = 1'b1;
    tick();
    bus.die1 = 1'b0; bus.die2 = 1'b0;
    tests++;
    if (bus.state !== S_OVER || bus.winner !== 2'b11) begin
      fails++; $display("FAIL crash_draw got=%b exp state=3 winner=11", dut_vec());
    end
    tick();
  endtask

  task automatic test_bombs();
    int c1, sc, nclr, guard;
    bus.levelS = 3'd3;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL bomb_count cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec());
      end
    end
    guard = 0;
    while (m_due != cyc + 1 && guard < 20) begin
      tick();
      guard++;
    end
    tests++;
    if (bus.state !== S_RUN || guard >= 20) begin
      fails++; $display("FAIL bomb_setup state=%0d guard=%0d exp state=2", bus.state, guard);
    end
    // Bomb edge lands on a period-end cycle: clear wins over scroll.
    bus.bom = 1'b1;
    tick();
    bus.bom = 1'b0;
    c1 = cyc;
    tests++;
    if (bus.clear !== 1'b1 || bus.scroll !== 1'b0 || bus.bombs_left !== 2'd1) begin
      fails++; $display("FAIL bomb_on_tick got=%b exp clear=1 scroll=0 bombs=1", dut_vec());
    end
    sc = -1;
    for (int i = 0; i < 30 && sc < 0; i++) begin
      tick();
      if (bus.scroll === 1'b1) sc = cyc;
    end
    tests++;
    if (sc - c1 !== 10) begin
      fails++; $display("FAIL bomb_retime scroll_after=%0d exp 10", sc - c1);
    end
    nclr = 1;
    for (int k = 0; k < 2; k++) begin
      bus.bom = 1'b1;
      tick();
      if (bus.clear === 1'b1) nclr++;
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL bomb_edge%0d got=%b exp=%b", k, dut_vec(), model_vec());
      end
      bus.bom = 1'b0;
      tick();
      tick();
    end
    tests++;
    if (nclr != 2 || bus.bombs_left !== 2'd0) begin
      fails++; $display("FAIL bomb_budget clears=%0d bombs=%0d exp 2 0", nclr, bus.bombs_left);
    end
    bus.die1 = 1'b1;
    tick();
    bus.die1 = 1'b0;
    tests++;
    if (bus.state !== S_OVER || bus.winner !== 2'b10) begin
      fails++; $display("FAIL crash_p2 got=%b exp state=3 winner=10", dut_vec());
    end
    tick();
  endtask

  task automatic test_die_bomb();
    bus.levelS = 3'($urandom_range(0, 7));
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int i = 0; i < 3 * period_of(m_lvl) + 3; i++) tick();
    tests++;
    if (bus.state !== S_RUN) begin
      fails++; $display("FAIL die_bomb_setup state=%0d exp 2", bus.state);
    end
    bus.die1 = 1'b1; bus.bom = 1'b1;
    tick();
    bus.die1 = 1'b0; bus.bom = 1'b0;
    tests++;
    if (bus.clear !== 1'b0 || bus.bombs_left !== 2'd2 || bus.state !== S_OVER || bus.winner !== 2'b10) begin
      fails++; $display("FAIL die_beats_bomb got=%b exp clear=0 bombs=2 state=3 winner=10", dut_vec());
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    bus.levelS = 3'd5;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    tests++;
    if (bus.state !== S_RUN) begin
      fails++; $display("FAIL rst_setup state=%0d exp 2", bus.state);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (dut_vec() !== RESET_VEC) begin
      fails++; $display("FAIL rst_async got=%b exp=%b", dut_vec(), RESET_VEC);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      bus.bom  = 1'($urandom_range(0, 1));
      bus.die1 = 1'($urandom_range(0, 1));
      tick();
      if (bus.scroll === 1'b1 || bus.clear === 1'b1) pulses++;
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL rst_after cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec());
      end
    end
    bus.bom = 1'b0; bus.die1 = 1'b0;
    tests++;
    if (pulses != 0) begin
      fails++; $display("FAIL rst_no_pulse pulses=%0d exp 0", pulses);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bus.start  = ($urandom_range(0, 39) == 0);
      bus.bom    = ($urandom_range(0, 14) == 0);
      bus.die1   = ($urandom_range(0, 89) == 0);
      bus.die2   = ($urandom_range(0, 89) == 0);
      bus.levelS = 3'($urandom_range(0, 7));
      tick();
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.levelS = 3'd0; bus.die1 = 1'b0; bus.die2 = 1'b0; bus.bom = 1'b0;
    model_reset();
    test_reset();
    test_level0();
    test_crash_p1();
    test_restart_level7();
    test_bombs();
    test_die_bomb();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
